pipelined_priority_encoder: RTL and testbench

- 2^N:N priority encoder, the inverse of the team's N:2^N one-hot decoder: converts a request/one-hot vector back to a binary index.
- Two-stage registered pipeline with valid/ready handshakes on both sides, so it can sit between arbitration logic and downstream consumers without a long combinational path.
- Flags "no bit set" and "more than one bit set" per transaction, and keeps a saturating count of multi-hot inputs for debug.

---
 rtl/pipelined_priority_encoder_pkg.sv | 13 +
 rtl/encoder_defs.vh | 6 +
 rtl/priority_half_enc.sv | 39 +++
 rtl/pipelined_priority_encoder.sv | 159 +++++++++++++++
 tb/tb_pipelined_priority_encoder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_priority_encoder_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
package pipelined_priority_encoder_pkg;

`include "encoder_defs.vh"

   localparam int ERR_W = 8;
   localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == ERR_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/encoder_defs.vh
// Priority-direction constants shared by the priority encoder files.
`ifndef ENCODER_DEFS_VH
`define ENCODER_DEFS_VH
localparam int PRIO_MSB = 0;
localparam int PRIO_LSB = 1;
`endif

// File: rtl/priority_half_enc.sv
// Combinational 2^M:M priority encoder with any / multi-hot flags.
module priority_half_enc
   import pipelined_priority_encoder_pkg::*;
#(
   parameter int M            = 2,
   parameter int LSB_PRIORITY = PRIO_MSB
) (
   input  logic [2**M-1:0] vec,
   output logic            any,
   output logic [M-1:0]    idx,
   output logic            multi
);

   localparam int V = 2**M;

   always_comb begin
      any   = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < V; i++) begin
         multi = multi | (any & vec[i]);
         any   = any | vec[i];
      end
   end

   // Scan toward the winning end so the last hit seen is the winner.
   always_comb begin
      idx = '0;
      if (LSB_PRIORITY == PRIO_LSB) begin
         for (int i = V - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[M-1:0];
         end
      end else begin
         for (int i = 0; i < V; i++) begin
            if (vec[i]) idx = i[M-1:0];
         end
      end
   end

endmodule

// File: rtl/pipelined_priority_encoder.sv
// Two-stage valid/ready 2^N:N priority encoder with zero / multi-hot flags
// and a saturating multi-hot counter.
module pipelined_priority_encoder
   import pipelined_priority_encoder_pkg::*;
#(
   parameter int N            = 3,
   parameter int LSB_PRIORITY = PRIO_MSB
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2**N-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_index,
   output logic             out_zero,
   output logic             out_multi,
   input  logic             err_clr,
   output logic [ERR_W-1:0] err_count
);

   localparam int W = 2**N;
   localparam int H = W / 2;
   localparam int M = N - 1;

   logic         hi_any, lo_any;
   logic [M-1:0] hi_idx, lo_idx;
   logic         hi_multi, lo_multi;

   priority_half_enc #(.M(M), .LSB_PRIORITY(LSB_PRIORITY)) u_hi (
      .vec   (in_data[W-1:H]),
      .any   (hi_any),
      .idx   (hi_idx),
      .multi (hi_multi)
   );

   priority_half_enc #(.M(M), .LSB_PRIORITY(LSB_PRIORITY)) u_lo (
      .vec   (in_data[H-1:0]),
      .any   (lo_any),
      .idx   (lo_idx),
      .multi (lo_multi)
   );

   logic             s1_valid_q, s1_valid_d;
   logic             hi_any_q, hi_any_d;
   logic [M-1:0]     hi_idx_q, hi_idx_d;
   logic             hi_multi_q, hi_multi_d;
   logic             lo_any_q, lo_any_d;
   logic [M-1:0]     lo_idx_q, lo_idx_d;
   logic             lo_multi_q, lo_multi_d;
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     out_index_q, out_index_d;
   logic             out_zero_q, out_zero_d;
   logic             out_multi_q, out_multi_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   logic         s1_ready, s2_ready;
   logic         in_fire, s1_fire, out_fire;
   logic         prefer_hi;
   logic         s2_zero, s2_multi;
   logic [N-1:0] s2_index;

   always_comb begin
      s2_ready = !out_valid_q || out_ready;
      s1_ready = !s1_valid_q || s2_ready;
      in_fire  = in_valid && s1_ready;
      s1_fire  = s1_valid_q && s2_ready;
      out_fire = out_valid_q && out_ready;
   end

   // Merge the two half results held in stage 1.
   always_comb begin
      if (LSB_PRIORITY == PRIO_LSB) prefer_hi = !lo_any_q;
      else                          prefer_hi = hi_any_q;
      s2_zero  = !hi_any_q && !lo_any_q;
      s2_multi = hi_multi_q || lo_multi_q || (hi_any_q && lo_any_q);
      if (s2_zero)        s2_index = '0;
      else if (prefer_hi) s2_index = {1'b1, hi_idx_q};
      else                s2_index = {1'b0, lo_idx_q};
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      hi_any_d   = hi_any_q;
      hi_idx_d   = hi_idx_q;
      hi_multi_d = hi_multi_q;
      lo_any_d   = lo_any_q;
      lo_idx_d   = lo_idx_q;
      lo_multi_d = lo_multi_q;
      if (s1_ready) s1_valid_d = in_valid;
      if (in_fire) begin
         hi_any_d   = hi_any;
         hi_idx_d   = hi_idx;
         hi_multi_d = hi_multi;
         lo_any_d   = lo_any;
         lo_idx_d   = lo_idx;
         lo_multi_d = lo_multi;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;
      out_zero_d  = out_zero_q;
      out_multi_d = out_multi_q;
      if (s2_ready) out_valid_d = s1_valid_q;
      if (s1_fire) begin
         out_index_d = s2_index;
         out_zero_d  = s2_zero;
         out_multi_d = s2_multi;
      end
   end

   // Clear takes precedence over a same-cycle increment.
   always_comb begin
      err_count_d = err_count_q;
      if (err_clr)                     err_count_d = '0;
      else if (out_fire && out_multi_q) err_count_d = sat_inc(err_count_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         hi_any_q    <= 1'b0;
         hi_idx_q    <= '0;
         hi_multi_q  <= 1'b0;
         lo_any_q    <= 1'b0;
         lo_idx_q    <= '0;
         lo_multi_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_zero_q  <= 1'b0;
         out_multi_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         hi_any_q    <= hi_any_d;
         hi_idx_q    <= hi_idx_d;
         hi_multi_q  <= hi_multi_d;
         lo_any_q    <= lo_any_d;
         lo_idx_q    <= lo_idx_d;
         lo_multi_q  <= lo_multi_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_zero_q  <= out_zero_d;
         out_multi_q <= out_multi_d;
         err_count_q <= err_count_d;
      end
   end

   assign in_ready  = s1_ready;
   assign out_valid = out_valid_q;
   assign out_index = out_index_q;
   assign out_zero  = out_zero_q;
   assign out_multi = out_multi_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_pipelined_priority_encoder.sv
// Directed self-checking bench for pipelined_priority_encoder (MSB and LSB
// priority instances driven from the same stimulus).
module tb_pipelined_priority_encoder;
   import pipelined_priority_encoder_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;
   logic       err_clr;

   logic       in_ready, out_valid, out_zero, out_multi;
   logic [2:0] out_index;
   logic [7:0] err_count;

   logic       in_ready_l, out_valid_l, out_zero_l, out_multi_l;
   logic [2:0] out_index_l;
   logic [7:0] err_count_l;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipelined_priority_encoder #(.N(3), .LSB_PRIORITY(PRIO_MSB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_zero  (out_zero),
      .out_multi (out_multi),
      .err_clr   (err_clr),
      .err_count (err_count)
   );

   pipelined_priority_encoder #(.N(3), .LSB_PRIORITY(PRIO_LSB)) dut_l (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_l),
      .in_data   (in_data),
      .out_valid (out_valid_l),
      .out_ready (out_ready),
      .out_index (out_index_l),
      .out_zero  (out_zero_l),
      .out_multi (out_multi_l),
      .err_clr   (err_clr),
      .err_count (err_count_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_out_multi", 32'(out_multi), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      step();
      step();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: multi-hot 0x90, MSB wins -> 7, LSB wins -> 4
      in_valid = 1'b1;
      in_data  = 8'h90;
      step();
      in_valid = 1'b0;
      chk("t1_not_yet", 32'(out_valid), 32'd0);
      step();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_index", 32'(out_index), 32'd7);
      chk("t1_zero", 32'(out_zero), 32'd0);
      chk("t1_multi", 32'(out_multi), 32'd1);
      chk("t1_lsb_index", 32'(out_index_l), 32'd4);
      chk("t1_lsb_multi", 32'(out_multi_l), 32'd1);
      step();
      chk("t1_err_count", 32'(err_count), 32'd1);
      chk("t1_drained", 32'(out_valid), 32'd0);

      // 2: one-hot sweep back to back
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            in_valid = 1'b1;
            in_data  = 8'(1 << k);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (k >= 1 && k <= 8) begin
            chk($sformatf("t2_valid_%0d", k - 1), 32'(out_valid), 32'd1);
            chk($sformatf("t2_index_%0d", k - 1), 32'(out_index), 32'(k - 1));
            chk($sformatf("t2_lsb_index_%0d", k - 1), 32'(out_index_l),
                32'(k - 1));
            chk($sformatf("t2_multi_%0d", k - 1), 32'(out_multi), 32'd0);
            chk($sformatf("t2_zero_%0d", k - 1), 32'(out_zero), 32'd0);
         end
      end
      chk("t2_err_count", 32'(err_count), 32'd1);
      chk("t2_drained", 32'(out_valid), 32'd0);

      // 3: zero vector
      in_valid = 1'b1;
      in_data  = 8'h00;
      step();
      in_valid = 1'b0;
      step();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_zero", 32'(out_zero), 32'd1);
      chk("t3_index", 32'(out_index), 32'd0);
      chk("t3_multi", 32'(out_multi), 32'd0);
      chk("t3_lsb_zero", 32'(out_zero_l), 32'd1);
      chk("t3_lsb_index", 32'(out_index_l), 32'd0);
      step();

      // 4: backpressure with 0x04, 0x40, 0x01
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h04;
      step();
      in_data = 8'h40;
      chk("t4_ready_2nd", 32'(in_ready), 32'd1);
      step();
      in_data = 8'h01;
      chk("t4_ready_3rd", 32'(in_ready), 32'd0);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_index_a", 32'(out_index), 32'd2);
      step();
      chk("t4_hold_index_b", 32'(out_index), 32'd2);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      step();
      chk("t4_hold_index_c", 32'(out_index), 32'd2);
      chk("t4_hold_multi", 32'(out_multi), 32'd0);
      out_ready = 1'b1;
      #1;
      chk("t4_ready_comb", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("t4_out_6", 32'(out_index), 32'd6);
      chk("t4_out_6_valid", 32'(out_valid), 32'd1);
      step();
      chk("t4_out_0", 32'(out_index), 32'd0);
      chk("t4_out_0_valid", 32'(out_valid), 32'd1);
      chk("t4_out_0_zero", 32'(out_zero), 32'd0);
      step();
      chk("t4_drained", 32'(out_valid), 32'd0);
      chk("t4_err_count", 32'(err_count), 32'd1);

      // 5: 300 multi-hot vectors saturate the counter
      in_valid = 1'b1;
      in_data  = 8'h03;
      for (int i = 0; i < 300; i++) step();
      in_valid = 1'b0;
      step();
      step();
      chk("t5_saturated", 32'(err_count), 32'(ERR_MAX));
      chk("t5_lsb_saturated", 32'(err_count_l), 32'd255);
      in_valid = 1'b1;
      in_data  = 8'h81;
      step();
      in_valid = 1'b0;
      step();
      chk("t5_multi_pending", 32'(out_multi), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t5_clr_wins", 32'(err_count), 32'd0);

      // 6: reset with both stages full
      in_valid = 1'b1;
      in_data  = 8'h0C;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("t6_err_pre", 32'(err_count), 32'd1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h02;
      step();
      in_data = 8'h08;
      step();
      in_valid = 1'b0;
      chk("t6_full_valid", 32'(out_valid), 32'd1);
      chk("t6_full_ready", 32'(in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(out_valid), 32'd0);
      chk("t6_async_err", 32'(err_count), 32'd0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      chk("t6_ready_after", 32'(in_ready), 32'd1);
      chk("t6_valid_after", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h20;
      step();
      in_valid = 1'b0;
      chk("t6_lat_early", 32'(out_valid), 32'd0);
      step();
      chk("t6_lat_valid", 32'(out_valid), 32'd1);
      chk("t6_index", 32'(out_index), 32'd5);
      step();
      chk("t6_no_dup", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
